// File: rtl/uart_pkg.sv
// uart_pkg: shared defaults and divisor type for the UART baud tick generator.
package uart_pkg;
  localparam int UART_INT_W        = 16;
  localparam int UART_FRAC_W       = 4;
  localparam int UART_OVERSAMPLE   = 16;
  localparam int UART_DEF_DIV_INT  = 27;
  localparam int UART_DEF_DIV_FRAC = 2;
  typedef struct packed {
    logic [UART_INT_W-1:0]  div_int;
    logic [UART_FRAC_W-1:0] div_frac;
  } uart_div_t;
endpackage

// File: rtl/baud_frac_div.sv
// baud_frac_div: integer+fractional period counter producing the raw oversample tick.
module baud_frac_div
  import uart_pkg::*;
#(
  parameter int INT_W  = UART_INT_W,
  parameter int FRAC_W = UART_FRAC_W
) (
  input  logic              clk_i,
  input  logic              rst_ni,
  input  logic              en_i,
  input  logic              clr_i,
  input  logic [INT_W-1:0]  div_int_i,
  input  logic [FRAC_W-1:0] div_frac_i,
  output logic              tick_o
);
  localparam int W = INT_W + 1;
  logic [W-1:0]      cnt_q, cnt_d, last;
  logic [INT_W-1:0]  dv;
  logic [FRAC_W-1:0] acc_q, acc_d;
  logic              ext_q, ext_d;
  logic [FRAC_W:0]   sum;
  always_comb begin
    dv     = (div_int_i == '0) ? INT_W'(1) : div_int_i;
    last   = W'(dv) + W'(ext_q) - W'(1);
    tick_o = en_i & ~clr_i & (cnt_q == last);
    sum    = {1'b0, acc_q} + {1'b0, div_frac_i};
    cnt_d  = clr_i ? '0 : tick_o ? '0 : en_i ? cnt_q + 1'b1 : cnt_q;
    {ext_d, acc_d} = clr_i ? '0 : tick_o ? sum : {ext_q, acc_q};
  end
  always_ff @(posedge clk_i or negedge rst_ni)
    if (!rst_ni) begin
      cnt_q <= '0;
      acc_q <= '0;
      ext_q <= 1'b0;
    end else begin
      cnt_q <= cnt_d;
      acc_q <= acc_d;
      ext_q <= ext_d;
    end
endmodule

// File: rtl/uart_baud_gen_frac.sv
// uart_baud_gen_frac: programmable fractional baud generator with shadowed divisor and bit tick.
module uart_baud_gen_frac
  import uart_pkg::*;
#(
  parameter int INT_W        = UART_INT_W,
  parameter int FRAC_W       = UART_FRAC_W,
  parameter int OVERSAMPLE   = UART_OVERSAMPLE,
  parameter int DEF_DIV_INT  = UART_DEF_DIV_INT,
  parameter int DEF_DIV_FRAC = UART_DEF_DIV_FRAC
) (
  input  logic              clock_i,
  input  logic              reset_n_i,
  input  logic              enable_i,
  input  logic [INT_W-1:0]  div_int_i,
  input  logic [FRAC_W-1:0] div_frac_i,
  input  logic              div_load_i,
  input  logic              sync_clr_i,
  output logic              rx_tick_o,
  output logic              tx_tick_o,
  output logic              div_pending_o
);
  localparam int OS_W = $clog2(OVERSAMPLE);
  localparam int DW   = INT_W + FRAC_W;
  logic [DW-1:0]   shadow_q, shadow_d, active_q, active_d;
  logic            pending_q, pending_d, rx_q, tx_q;
  logic [OS_W-1:0] os_q, os_d;
  logic            raw, bit_end, apply;
  baud_frac_div #(.INT_W(INT_W), .FRAC_W(FRAC_W)) u_div (
    .clk_i     (clock_i),
    .rst_ni    (reset_n_i),
    .en_i      (enable_i),
    .clr_i     (sync_clr_i),
    .div_int_i (active_q[DW-1:FRAC_W]),
    .div_frac_i(active_q[FRAC_W-1:0]),
    .tick_o    (raw)
  );
  // Retune only on a bit boundary while running so no bit is ever split across divisors.
  always_comb begin
    bit_end   = raw & (os_q == OS_W'(OVERSAMPLE - 1));
    apply     = pending_q & ~sync_clr_i & (~enable_i | bit_end);
    shadow_d  = div_load_i ? {div_int_i, div_frac_i} : shadow_q;
    pending_d = div_load_i | (pending_q & ~apply);
    active_d  = apply ? shadow_q : active_q;
    os_d      = sync_clr_i ? '0 : raw ? os_q + 1'b1 : os_q;
  end
  always_ff @(posedge clock_i or negedge reset_n_i)
    if (!reset_n_i) begin
      shadow_q  <= '0;
      active_q  <= {INT_W'(DEF_DIV_INT), FRAC_W'(DEF_DIV_FRAC)};
      pending_q <= 1'b0;
      os_q      <= '0;
      rx_q      <= 1'b0;
      tx_q      <= 1'b0;
    end else begin
      shadow_q  <= shadow_d;
      active_q  <= active_d;
      pending_q <= pending_d;
      os_q      <= os_d;
      rx_q      <= raw;
      tx_q      <= bit_end;
    end
  assign rx_tick_o     = rx_q;
  assign tx_tick_o     = tx_q;
  assign div_pending_o = pending_q;
endmodule

// File: tb/tb_uart_baud_gen_frac.sv
// tb_uart_baud_gen_frac: scoreboard bench timing rx/tx ticks against expected cycle numbers.
module tb_uart_baud_gen_frac;
  logic        clk = 0, rst_n = 0, en = 0, load = 0, clr = 0;
  logic [15:0] dint = 0;
  logic [3:0]  dfrac = 0;
  logic        rx, tx, pend;
  int          cyc = 0, errors = 0, checks = 0, e;
  int          rx_q[$], tx_q[$];

  uart_baud_gen_frac dut (
    .clock_i(clk), .reset_n_i(rst_n), .enable_i(en), .div_int_i(dint), .div_frac_i(dfrac),
    .div_load_i(load), .sync_clr_i(clr), .rx_tick_o(rx), .tx_tick_o(tx), .div_pending_o(pend)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string nm, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d (cyc %0d)", nm, act, exp, cyc);
    end
  endtask

  always @(negedge clk) begin
    if (rx) begin
      if (rx_q.size() == 0) chk("rx_unexpected", cyc, -1);
      else chk("rx_time", cyc, rx_q.pop_front());
    end
    if (tx) begin
      if (tx_q.size() == 0) chk("tx_unexpected", cyc, -1);
      else chk("tx_time", cyc, tx_q.pop_front());
    end
  end

  task automatic step(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic drain();
    chk("rx_missing", rx_q.size(), 0);
    chk("tx_missing", tx_q.size(), 0);
    rx_q.delete();
    tx_q.delete();
  endtask

  task automatic load_div(input int i, input int f);
    en = 0; load = 1; dint = 16'(i); dfrac = 4'(f);
    step(1);
    load = 0;
    chk("pend_after_load", pend, 1);
    step(1);
    chk("pend_after_apply", pend, 0);
    clr = 1;
    step(1);
    clr = 0;
  endtask

  task automatic go(input int d, input int f, input int n);
    int t, acc, ext, s;
    t = cyc; acc = 0; ext = 0; en = 1;
    for (int k = 1; k <= n; k++) begin
      t += d + ext;
      rx_q.push_back(t);
      if (k % 16 == 0) tx_q.push_back(t);
      s = acc + f; ext = s >> 4; acc = s & 15;
    end
    step(t - cyc);
    en = 0;
    step(2);
    drain();
  endtask

  initial begin
    step(2);
    chk("reset_rx", rx, 0);
    chk("reset_tx", tx, 0);
    chk("reset_pend", pend, 0);
    rst_n = 1;
    load_div(4, 0);
    go(4, 0, 40);
    load_div(4, 8);
    go(4, 8, 33);
    // retune mid-bit: old spacing until the bit tick, then 10
    load_div(4, 0);
    e = cyc; en = 1;
    for (int k = 1; k <= 16; k++) rx_q.push_back(e + 4 * k);
    for (int j = 1; j <= 4; j++) rx_q.push_back(e + 64 + 10 * j);
    tx_q.push_back(e + 64);
    step(21);
    load = 1; dint = 10; dfrac = 0;
    step(1);
    load = 0;
    chk("pend_mid_bit", pend, 1);
    step(41);
    chk("pend_before_tx", pend, 1);
    step(1);
    chk("pend_after_tx", pend, 0);
    step(40);
    en = 0;
    step(2);
    drain();
    // enable low 7 clocks mid-period
    load_div(4, 0);
    e = cyc; en = 1;
    rx_q.push_back(e + 4); rx_q.push_back(e + 8); rx_q.push_back(e + 19);
    rx_q.push_back(e + 23); rx_q.push_back(e + 27);
    step(10);
    en = 0;
    step(7);
    en = 1;
    step(10);
    en = 0;
    step(2);
    drain();
    // phase clear at os_cnt=5
    load_div(4, 0);
    e = cyc; en = 1;
    for (int k = 1; k <= 5; k++) rx_q.push_back(e + 4 * k);
    for (int j = 1; j <= 16; j++) rx_q.push_back(e + 23 + 4 * j);
    tx_q.push_back(e + 87);
    step(22);
    clr = 1;
    step(1);
    clr = 0;
    step(64);
    en = 0;
    step(2);
    drain();
    load_div(0, 0);
    go(1, 0, 20);
    load_div(1, 0);
    go(1, 0, 20);
    load_div(1, 8);
    go(1, 8, 24);
    // reset mid-run drops pending load and restores default divisor
    load_div(4, 0);
    e = cyc; en = 1;
    rx_q.push_back(e + 4); rx_q.push_back(e + 8);
    step(9);
    load = 1; dint = 10;
    step(1);
    load = 0;
    chk("pend_before_reset", pend, 1);
    #2 rst_n = 0;
    step(3);
    chk("rst_mid_rx", rx, 0);
    chk("rst_mid_tx", tx, 0);
    chk("rst_mid_pend", pend, 0);
    drain();
    rst_n = 1;
    go(27, 2, 17);
    chk("pend_after_reset", pend, 0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
